// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, ALU opcodes and the immediate extender
// used by the ID/EX operand stage.
package cpu_pkg;

    localparam int DATA_W  = 32;
    localparam int RA_W    = 5;
    localparam int IMM_W   = 16;
    localparam int ALUOP_W = 5;

    localparam logic [ALUOP_W-1:0] ALU_NOP = 5'b00000;
    localparam logic [ALUOP_W-1:0] ALU_ADD = 5'b00001;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 5'b00010;
    localparam logic [ALUOP_W-1:0] ALU_AND = 5'b00011;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 5'b00100;
    localparam logic [ALUOP_W-1:0] ALU_NOT = 5'b00101;
    localparam logic [ALUOP_W-1:0] ALU_XOR = 5'b00110;
    localparam logic [ALUOP_W-1:0] ALU_SLL = 5'b00111;
    localparam logic [ALUOP_W-1:0] ALU_SRL = 5'b01000;
    localparam logic [ALUOP_W-1:0] ALU_LT  = 5'b01001;
    localparam logic [ALUOP_W-1:0] ALU_LE  = 5'b01010;
    localparam logic [ALUOP_W-1:0] ALU_GT  = 5'b01011;
    localparam logic [ALUOP_W-1:0] ALU_EQ  = 5'b01100;
    localparam logic [ALUOP_W-1:0] ALU_NE  = 5'b01101;
    localparam logic [ALUOP_W-1:0] ALU_GE  = 5'b01110;
    localparam logic [ALUOP_W-1:0] ALU_LUI = 5'b01111;

    // Widen the immediate field by replicating its MSB or by zero fill.
    function automatic logic [DATA_W-1:0] ext_imm(input logic [IMM_W-1:0] imm,
                                                  input logic sext);
        logic [DATA_W-1:0] res;
        if (sext) begin
            res = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
        end else begin
            res = {{(DATA_W-IMM_W){1'b0}}, imm};
        end
        return res;
    endfunction

endpackage

// File: rtl/ex_operand_stage_if.sv
// Bundle of decode, hazard, writeback and ALU-side signals around the ID/EX stage.
// The slave modport is the stage itself; master is its environment.
interface ex_operand_stage_if;
    import cpu_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [ALUOP_W-1:0]  in_aluop;
    logic [RA_W-1:0]     in_rs;
    logic [RA_W-1:0]     in_rt;
    logic [RA_W-1:0]     in_rd;
    logic [DATA_W-1:0]   in_rs_data;
    logic [DATA_W-1:0]   in_rt_data;
    logic [IMM_W-1:0]    in_imm;
    logic                in_use_imm;
    logic                in_imm_sext;
    logic [4:0]          in_smt;
    logic                in_we;
    logic                exm_valid;
    logic                exm_we;
    logic                exm_load;
    logic [RA_W-1:0]     exm_rd;
    logic [DATA_W-1:0]   exm_data;
    logic                wb_we;
    logic [RA_W-1:0]     wb_rd;
    logic [DATA_W-1:0]   wb_data;
    logic                flush;
    logic                out_ready;
    logic                out_valid;
    logic [DATA_W-1:0]   op1;
    logic [DATA_W-1:0]   op2;
    logic [4:0]          smt;
    logic [ALUOP_W-1:0]  aluop;
    logic [RA_W-1:0]     out_rd;
    logic                out_we;

    modport slave (
        input  in_valid, in_aluop, in_rs, in_rt, in_rd, in_rs_data, in_rt_data,
               in_imm, in_use_imm, in_imm_sext, in_smt, in_we,
               exm_valid, exm_we, exm_load, exm_rd, exm_data,
               wb_we, wb_rd, wb_data, flush, out_ready,
        output in_ready, out_valid, op1, op2, smt, aluop, out_rd, out_we
    );

    modport master (
        output in_valid, in_aluop, in_rs, in_rt, in_rd, in_rs_data, in_rt_data,
               in_imm, in_use_imm, in_imm_sext, in_smt, in_we,
               exm_valid, exm_we, exm_load, exm_rd, exm_data,
               wb_we, wb_rd, wb_data, flush, out_ready,
        input  in_ready, out_valid, op1, op2, smt, aluop, out_rd, out_we
    );

endinterface

// File: rtl/fwd_mux.sv
// Combinational bypass select for one source register: r0, EX/MEM, MEM/WB, then regfile.
module fwd_mux
    import cpu_pkg::*;
(
    input  logic [RA_W-1:0]   idx,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              exm_valid,
    input  logic              exm_we,
    input  logic              exm_load,
    input  logic [RA_W-1:0]   exm_rd,
    input  logic [DATA_W-1:0] exm_data,
    input  logic              wb_we,
    input  logic [RA_W-1:0]   wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] data
);

    // Priority bypass; a load in EX/MEM has no data yet and is handled as a stall.
    always_comb begin
        data = rf_data;
        if (idx == {RA_W{1'b0}}) begin
            data = {DATA_W{1'b0}};
        end else if (exm_valid && exm_we && !exm_load && (exm_rd == idx)) begin
            data = exm_data;
        end else if (wb_we && (wb_rd == idx)) begin
            data = wb_data;
        end else begin
            data = rf_data;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register stage: captures a decoded ALU op with bypassed operands, holds it
// under downstream stall while snooping writeback, and drives the ALU from flops.
module ex_operand_stage
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    ex_operand_stage_if.slave  bus
);

    logic                load_use_s;
    logic                ready_s;
    logic                capture_s;
    logic [DATA_W-1:0]   rs_fwd_s;
    logic [DATA_W-1:0]   rt_fwd_s;
    logic [DATA_W-1:0]   op2_sel_s;

    logic                valid_r;
    logic [DATA_W-1:0]   op1_r;
    logic [DATA_W-1:0]   op2_r;
    logic [4:0]          smt_r;
    logic [ALUOP_W-1:0]  aluop_r;
    logic [RA_W-1:0]     rd_r;
    logic                we_r;
    logic [RA_W-1:0]     rs_tag_r;
    logic [RA_W-1:0]     rt_tag_r;
    logic                use_imm_r;

    fwd_mux u_fwd_rs (
        .idx(bus.in_rs), .rf_data(bus.in_rs_data),
        .exm_valid(bus.exm_valid), .exm_we(bus.exm_we), .exm_load(bus.exm_load),
        .exm_rd(bus.exm_rd), .exm_data(bus.exm_data),
        .wb_we(bus.wb_we), .wb_rd(bus.wb_rd), .wb_data(bus.wb_data),
        .data(rs_fwd_s)
    );

    fwd_mux u_fwd_rt (
        .idx(bus.in_rt), .rf_data(bus.in_rt_data),
        .exm_valid(bus.exm_valid), .exm_we(bus.exm_we), .exm_load(bus.exm_load),
        .exm_rd(bus.exm_rd), .exm_data(bus.exm_data),
        .wb_we(bus.wb_we), .wb_rd(bus.wb_rd), .wb_data(bus.wb_data),
        .data(rt_fwd_s)
    );

    // Load-use hazard and the resulting upstream handshake.
    always_comb begin
        load_use_s = bus.exm_valid && bus.exm_we && bus.exm_load &&
                     (bus.exm_rd != {RA_W{1'b0}}) &&
                     ((bus.exm_rd == bus.in_rs) ||
                      ((bus.exm_rd == bus.in_rt) && !bus.in_use_imm));
        ready_s    = (!valid_r || bus.out_ready) && !load_use_s && !bus.flush;
        capture_s  = bus.in_valid && ready_s;
        if (bus.in_use_imm) begin
            op2_sel_s = ext_imm(bus.in_imm, bus.in_imm_sext);
        end else begin
            op2_sel_s = rt_fwd_s;
        end
    end

    // Stage register: reset, flush, capture, drain, then hold with writeback snoop.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r   <= 1'b0;
            op1_r     <= {DATA_W{1'b0}};
            op2_r     <= {DATA_W{1'b0}};
            smt_r     <= 5'd0;
            aluop_r   <= ALU_NOP;
            rd_r      <= {RA_W{1'b0}};
            we_r      <= 1'b0;
            rs_tag_r  <= {RA_W{1'b0}};
            rt_tag_r  <= {RA_W{1'b0}};
            use_imm_r <= 1'b0;
        end else if (bus.flush) begin
            valid_r <= 1'b0;
            aluop_r <= ALU_NOP;
            rd_r    <= {RA_W{1'b0}};
            we_r    <= 1'b0;
        end else if (capture_s) begin
            valid_r   <= 1'b1;
            op1_r     <= rs_fwd_s;
            op2_r     <= op2_sel_s;
            smt_r     <= bus.in_smt;
            aluop_r   <= bus.in_aluop;
            rd_r      <= bus.in_rd;
            we_r      <= bus.in_we;
            rs_tag_r  <= bus.in_rs;
            rt_tag_r  <= bus.in_rt;
            use_imm_r <= bus.in_use_imm;
        end else if (valid_r && bus.out_ready) begin
            valid_r <= 1'b0;
            aluop_r <= ALU_NOP;
            rd_r    <= {RA_W{1'b0}};
            we_r    <= 1'b0;
        end else if (valid_r) begin
            // Held operands must not go stale while a producer retires beneath them.
            if (bus.wb_we && (bus.wb_rd != {RA_W{1'b0}}) && (bus.wb_rd == rs_tag_r)) begin
                op1_r <= bus.wb_data;
            end
            if (bus.wb_we && (bus.wb_rd != {RA_W{1'b0}}) && (bus.wb_rd == rt_tag_r) &&
                !use_imm_r) begin
                op2_r <= bus.wb_data;
            end
        end
    end

    assign bus.in_ready  = ready_s;
    assign bus.out_valid = valid_r;
    assign bus.op1       = op1_r;
    assign bus.op2       = op2_r;
    assign bus.smt       = smt_r;
    assign bus.aluop     = aluop_r;
    assign bus.out_rd    = rd_r;
    assign bus.out_we    = we_r;

endmodule
